// File: rtl/seq_mult_ctrl.sv
// Unsigned shift-and-add multiplier: one add/shift per clock for WIDTH clocks,
// then a one-cycle done pulse with the 2*WIDTH-bit product held until the next result.
module seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               c_q, c_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum;
  logic               last;

  assign last = (cnt_q == CW'(WIDTH - 1));

  // {C,A} + M; C is always zero here after each shift, so this is A + M with carry out.
  always_comb begin
    sum = {c_q, a_q};
    if (q_q[0]) sum = {c_q, a_q} + {1'b0, m_q};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Shift {C, A_sum, Q} right: carry into A msb, A_sum lsb into Q msb.
        c_d   = 1'b0;
        a_d   = sum[WIDTH:1];
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          product_d = {sum, q_q[WIDTH-1:1]};
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs registered from the next state so they never glitch.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: vector table of products plus multi-cycle corner cases.
module tb_seq_mult_ctrl;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int checks = 0;
  int errors = 0;

  seq_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   q;
    logic [2*WIDTH-1:0] exp;
    string              name;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full operation with exact latency checks; operands are scrambled after accept.
  task automatic run_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q,
                        input logic [2*WIDTH-1:0] exp, input string nm);
    logic [2*WIDTH-1:0] prev;
    prev = product;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    cyc();                        // edge k
    start        = 1'b0;
    multiplicand = ~m;
    multiplier   = q ^ 8'h5a;
    chk({nm, " busy@k"}, 32'(busy), 32'd1);
    chk({nm, " done@k"}, 32'(done), 32'd0);
    for (int i = 1; i < WIDTH; i++) begin
      cyc();
      chk({nm, " busy calc"}, 32'(busy), 32'd1);
      chk({nm, " done calc"}, 32'(done), 32'd0);
      chk({nm, " prod held calc"}, 32'(product), 32'(prev));
    end
    cyc();                        // edge k+WIDTH
    chk({nm, " done@k+W"}, 32'(done), 32'd1);
    chk({nm, " busy@k+W"}, 32'(busy), 32'd1);
    chk({nm, " product"}, 32'(product), 32'(exp));
    cyc();                        // edge k+WIDTH+1
    chk({nm, " done@k+W+1"}, 32'(done), 32'd0);
    chk({nm, " busy@k+W+1"}, 32'(busy), 32'd0);
    chk({nm, " product held"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int ndone;
    int t1;
    int t2;
    logic [2*WIDTH-1:0] p1;
    logic [2*WIDTH-1:0] p2;

    vecs[0] = '{8'd13,  8'd11,  16'd143,   "13x11"};
    vecs[1] = '{8'd255, 8'd255, 16'd65025, "255x255"};
    vecs[2] = '{8'd0,   8'd200, 16'd0,     "0x200"};
    vecs[3] = '{8'd200, 8'd0,   16'd0,     "200x0"};
    vecs[4] = '{8'd1,   8'd1,   16'd1,     "1x1"};
    vecs[5] = '{8'd128, 8'd2,   16'd256,   "128x2"};
    vecs[6] = '{8'd170, 8'd85,  16'd14450, "170x85"};

    rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    cyc(); cyc();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset product", 32'(product), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle busy", 32'(busy), 32'd0);

    foreach (vecs[i]) run_op(vecs[i].m, vecs[i].q, vecs[i].exp, vecs[i].name);

    // Start while busy must be ignored.
    multiplicand = 8'd6; multiplier = 8'd7; start = 1'b1;
    cyc();                        // k
    start = 1'b0; multiplicand = 8'd33; multiplier = 8'd44;
    cyc(); cyc();                 // k+2
    multiplicand = 8'd9; multiplier = 8'd9; start = 1'b1;
    cyc();                        // k+3
    start = 1'b0; multiplicand = 8'd77; multiplier = 8'd99;
    ndone = 0; p1 = '0;
    for (int c = 4; c <= 24; c++) begin
      cyc();
      if (done) begin
        ndone++;
        p1 = product;
        chk("ignored start done edge", 32'(c), 32'd8);
      end
      if (c == 10) chk("ignored start busy@k+10", 32'(busy), 32'd0);
    end
    chk("ignored start ndone", 32'(ndone), 32'd1);
    chk("ignored start product", 32'(p1), 32'd42);

    // Reset mid-operation abandons it.
    multiplicand = 8'd100; multiplier = 8'd3; start = 1'b1;
    cyc();                        // k
    start = 1'b0;
    cyc(); cyc(); cyc(); cyc();   // k+4
    #3 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst product", 32'(product), 32'd0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (done) ndone++;
    end
    chk("midrst no done", 32'(ndone), 32'd0);
    rst_n = 1'b1;
    run_op(8'd5, 8'd5, 16'd25, "post-reset 5x5");

    // Back-to-back with start held high.
    multiplicand = 8'd2; multiplier = 8'd3; start = 1'b1;
    cyc();                        // k
    multiplicand = 8'd4; multiplier = 8'd5;
    ndone = 0; t1 = -1; t2 = -1; p1 = '0; p2 = '0;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      if (ndone == 1 && !done) chk("b2b first held", 32'(product), 32'd6);
      if (done) begin
        ndone++;
        if (ndone == 1) begin t1 = c; p1 = product; end
        else if (ndone == 2) begin t2 = c; p2 = product; start = 1'b0; end
      end
    end
    chk("b2b ndone", 32'(ndone), 32'd2);
    chk("b2b first edge", 32'(t1), 32'd8);
    chk("b2b spacing", 32'(t2 - t1), 32'd10);
    chk("b2b p1", 32'(p1), 32'd6);
    chk("b2b p2", 32'(p2), 32'd20);
    chk("b2b idle after", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
